// File: rtl/pe_ctrl_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pe_ctrl_pkg
//  Description : Shared definitions for the PE controller family: the
//                IDLE/BURST state encoding used by the weight-bus arbiter
//                and the default sizing constants (4 PEs, 3x3 filter
//                bursts of 9 beats, 4-bit beat address).
//  Revision    : 1.0 - initial release
// ============================================================================
package pe_ctrl_pkg;

    typedef enum logic [0:0] {
        ST_IDLE  = 1'b0,
        ST_BURST = 1'b1
    } pe_state_e;

    localparam int C_N_REQ     = 4;
    localparam int C_BURST_LEN = 9;
    localparam int C_ADDR_W    = 4;

endpackage : pe_ctrl_pkg
`default_nettype wire

// File: rtl/pe_weight_arbiter_rr_pick.sv
`default_nettype none
// ============================================================================
//  Module      : rr_pick
//  Description : Combinational rotating priority encoder. Searches req
//                starting at last_winner+1 (mod N_REQ) and returns the first
//                requester as one-hot plus its index.
//                Build option PE_ARB_FIXED_PRIO_EN: when defined the rotation
//                is bypassed and the lowest-index requester wins.
//  Ports       : req[N_REQ]      - request vector
//                last_winner     - index of the previous winner
//                winner[N_REQ]   - one-hot selected requester (0 if none)
//                winner_idx      - index of selected requester
//                valid           - at least one request present
//  Revision    : 1.0 - initial release
// ============================================================================
module rr_pick
    import pe_ctrl_pkg::*;
#(
    parameter int N_REQ = C_N_REQ
) (
    input  logic [N_REQ-1:0]         req,
    input  logic [$clog2(N_REQ)-1:0] last_winner,
    output logic [N_REQ-1:0]         winner,
    output logic [$clog2(N_REQ)-1:0] winner_idx,
    output logic                     valid
);

    localparam int IDX_W = $clog2(N_REQ);

`ifdef PE_ARB_FIXED_PRIO_EN
    // Rotation pointer is not consulted in fixed-priority builds.
    logic w_unused_last;
    assign w_unused_last = ^last_winner;

    always_comb begin
        winner_idx = '0;
        // Walk downwards so the lowest index is the last one written.
        for (int i = N_REQ - 1; i >= 0; i--) begin
            if (req[i]) begin
                winner_idx = IDX_W'(i);
            end
        end
        valid  = |req;
        winner = valid ? (N_REQ'(1) << winner_idx) : '0;
    end
`else
    logic [IDX_W:0] w_cand;

    always_comb begin
        winner_idx = '0;
        w_cand     = '0;
        // Walk offsets from farthest to nearest so the nearest requester
        // after last_winner is the final (winning) assignment.
        for (int off = N_REQ; off >= 1; off--) begin
            w_cand = {1'b0, last_winner} + (IDX_W + 1)'(off);
            if (w_cand >= (IDX_W + 1)'(N_REQ)) begin
                w_cand = w_cand - (IDX_W + 1)'(N_REQ);
            end
            if (req[w_cand[IDX_W-1:0]]) begin
                winner_idx = w_cand[IDX_W-1:0];
            end
        end
        valid  = |req;
        winner = valid ? (N_REQ'(1) << winner_idx) : '0;
    end
`endif

endmodule : rr_pick
`default_nettype wire

// File: rtl/pe_weight_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : pe_weight_arbiter
//  Description : Arbitrates a shared weight bus among N_REQ PE controllers.
//                A winner is chosen in IDLE and owns the bus for a locked
//                burst of BURST_LEN beats (weight_addr 0..BURST_LEN-1),
//                followed by a one-cycle burst_done pulse. The owner can
//                cut its burst short with abort (no burst_done).
//                Build option PE_ARB_FIXED_PRIO_EN: lowest-index requester
//                always wins instead of round-robin.
//  Ports       : clk, rst (sync, active high)
//                req[N_REQ], abort[N_REQ]       - per-PE inputs
//                grant[N_REQ]                   - one-hot bus owner
//                weight_in_valid, weight_addr   - beat strobe / beat index
//                burst_done[N_REQ]              - completion pulse
//                busy                           - high while bursting
//  Revision    : 1.0 - initial release
// ============================================================================
module pe_weight_arbiter
    import pe_ctrl_pkg::*;
#(
    parameter int N_REQ     = C_N_REQ,
    parameter int BURST_LEN = C_BURST_LEN,
    parameter int ADDR_W    = C_ADDR_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [N_REQ-1:0]  req,
    input  logic [N_REQ-1:0]  abort,
    output logic [N_REQ-1:0]  grant,
    output logic              weight_in_valid,
    output logic [ADDR_W-1:0] weight_addr,
    output logic [N_REQ-1:0]  burst_done,
    output logic              busy
);

    localparam int                IDX_W       = $clog2(N_REQ);
    localparam logic [ADDR_W-1:0] C_LAST_BEAT = ADDR_W'(BURST_LEN - 1);
    localparam logic [IDX_W-1:0]  C_LAST_INIT = IDX_W'(N_REQ - 1);

    pe_state_e         r_state;
    logic [IDX_W-1:0]  r_last_winner;
    logic [N_REQ-1:0]  r_grant;
    logic              r_valid;
    logic [ADDR_W-1:0] r_addr;
    logic [N_REQ-1:0]  r_done;
    logic              r_busy;

    logic [N_REQ-1:0]  w_winner;
    logic [IDX_W-1:0]  w_winner_idx;
    logic              w_winner_valid;
    logic              w_abort_hit;

    rr_pick #(
        .N_REQ (N_REQ)
    ) u_rr_pick (
        .req         (req),
        .last_winner (r_last_winner),
        .winner      (w_winner),
        .winner_idx  (w_winner_idx),
        .valid       (w_winner_valid)
    );

    // Only the current owner's abort line matters; r_grant is zero in IDLE.
    assign w_abort_hit = |(abort & r_grant);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state       <= ST_IDLE;
            r_last_winner <= C_LAST_INIT;
            r_grant       <= '0;
            r_valid       <= 1'b0;
            r_addr        <= '0;
            r_done        <= '0;
            r_busy        <= 1'b0;
        end else begin
            r_done <= '0;
            case (r_state)
                ST_IDLE: begin
                    if (w_winner_valid) begin
                        r_state       <= ST_BURST;
                        r_grant       <= w_winner;
                        r_valid       <= 1'b1;
                        r_addr        <= '0;
                        r_busy        <= 1'b1;
                        // Pointer advances at grant time, so an aborted
                        // burst still counts as the owner's turn.
                        r_last_winner <= w_winner_idx;
                    end
                end
                ST_BURST: begin
                    if (w_abort_hit || (r_addr == C_LAST_BEAT)) begin
                        r_state <= ST_IDLE;
                        r_grant <= '0;
                        r_valid <= 1'b0;
                        r_addr  <= '0;
                        r_busy  <= 1'b0;
                        // Abort outranks completion on the final beat.
                        if (!w_abort_hit) begin
                            r_done <= r_grant;
                        end
                    end else begin
                        r_addr <= r_addr + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_IDLE;
                    r_grant <= '0;
                    r_valid <= 1'b0;
                    r_addr  <= '0;
                    r_busy  <= 1'b0;
                end
            endcase
        end
    end

    assign grant           = r_grant;
    assign weight_in_valid = r_valid;
    assign weight_addr     = r_addr;
    assign burst_done      = r_done;
    assign busy            = r_busy;

endmodule : pe_weight_arbiter
`default_nettype wire

// File: tb/tb_pe_weight_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pe_weight_arbiter
//  Description : Self-checking bench for pe_weight_arbiter (default sizing:
//                4 PEs, 9-beat bursts, 4-bit address). A behavioural model
//                tracks bus owner, beat number and rotation pointer as plain
//                integers and predicts every output each cycle. Directed
//                scenarios add explicit constant checks on key cycles.
//                Honours PE_ARB_FIXED_PRIO_EN like the design.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pe_weight_arbiter;

    localparam int N  = 4;
    localparam int BL = 9;
    localparam int AW = 4;

    logic          clk   = 1'b0;
    logic          rst   = 1'b1;
    logic [N-1:0]  req   = '0;
    logic [N-1:0]  abort = '0;

    wire [N-1:0]   grant;
    wire           weight_in_valid;
    wire [AW-1:0]  weight_addr;
    wire [N-1:0]   burst_done;
    wire           busy;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model state.
    int           m_owner = -1;   // -1 means the bus is idle
    int           m_beat  = 0;
    int           m_last  = N - 1;
    logic [N-1:0] m_done  = '0;
    logic [2*N+AW+1:0] exp_vec;
    wire  [2*N+AW+1:0] act_vec = {grant, weight_in_valid, weight_addr, burst_done, busy};

    pe_weight_arbiter #(
        .N_REQ     (N),
        .BURST_LEN (BL),
        .ADDR_W    (AW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .req             (req),
        .abort           (abort),
        .grant           (grant),
        .weight_in_valid (weight_in_valid),
        .weight_addr     (weight_addr),
        .burst_done      (burst_done),
        .busy            (busy)
    );

    always #5 clk = ~clk;

    // One clock: advance the model on the rising edge using the inputs the
    // bench is presenting, then return at the falling edge for sampling.
    task automatic tick();
        int cand;
        @(posedge clk);
        if (rst) begin
            m_owner = -1; m_beat = 0; m_last = N - 1; m_done = '0;
        end else if (m_owner < 0) begin
            m_done = '0;
            for (int off = 1; off <= N; off++) begin
`ifdef PE_ARB_FIXED_PRIO_EN
                cand = off - 1;
`else
                cand = (m_last + off) % N;
`endif
                if (m_owner < 0 && req[cand]) begin
                    m_owner = cand; m_beat = 0; m_last = cand;
                end
            end
        end else begin
            m_done = '0;
            if (abort[m_owner]) begin
                m_owner = -1; m_beat = 0;
            end else if (m_beat == BL - 1) begin
                m_done  = N'(1) << m_owner;
                m_owner = -1; m_beat = 0;
            end else begin
                m_beat++;
            end
        end
        if (m_owner >= 0)
            exp_vec = {N'(1) << m_owner, 1'b1, AW'(m_beat), m_done, 1'b1};
        else
            exp_vec = {{N{1'b0}}, 1'b0, {AW{1'b0}}, m_done, 1'b0};
        @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req = '0; abort = '0;
        tick();
        rst = 1'b0;
    endtask

    task automatic test_reset();
        rst = 1'b1;
        tick(); tick();
        n_checks++;
        if (act_vec !== '0) begin
            n_errors++; $display("FAIL reset_outputs: got %h required 0", act_vec);
        end
        n_checks++;
        if (act_vec !== exp_vec) begin
            n_errors++; $display("FAIL reset_model: got %h required %h", act_vec, exp_vec);
        end
        rst = 1'b0;
    endtask

    task automatic test_single();
        do_reset();
        req = 4'b0100;
        for (int c = 1; c <= 12; c++) begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_errors++; $display("FAIL single c%0d: got %h required %h", c, act_vec, exp_vec);
            end
            if (c == 1) begin
                n_checks++;
                if (grant !== 4'b0100 || weight_addr !== 4'd0) begin
                    n_errors++; $display("FAIL single_first_beat: grant %b addr %0d required 0100/0", grant, weight_addr);
                end
            end
            if (c == 9) begin
                n_checks++;
                if (weight_addr !== 4'd8) begin
                    n_errors++; $display("FAIL single_last_addr: got %0d required 8", weight_addr);
                end
            end
            if (c == 10) begin
                n_checks++;
                if (burst_done !== 4'b0100 || grant !== 4'b0000) begin
                    n_errors++; $display("FAIL single_done: done %b grant %b required 0100/0000", burst_done, grant);
                end
            end
            if (m_done != 0) req = '0;
        end
    endtask

    task automatic test_fairness();
        do_reset();
        req = 4'b1111;
        for (int c = 1; c <= 50; c++) begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_errors++; $display("FAIL fair c%0d: got %h required %h", c, act_vec, exp_vec);
            end
            if ((c - 1) % 10 == 0) begin
                n_checks++;
                if (grant !== (4'b0001 << (((c - 1) / 10) % 4))) begin
                    n_errors++; $display("FAIL fair_order c%0d: got %b required %b", c, grant, 4'b0001 << (((c - 1) / 10) % 4));
                end
            end
        end
        req = '0;
        for (int c = 0; c < 10; c++) tick();
    endtask

    task automatic test_abort();
        do_reset();
        req = 4'b0010;
        for (int c = 1; c <= 18; c++) begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_errors++; $display("FAIL abort c%0d: got %h required %h", c, act_vec, exp_vec);
            end
            if (c == 5) abort = 4'b0010;
            if (c == 6) begin
                n_checks++;
                if (grant !== '0 || weight_addr !== '0 || burst_done !== '0 || weight_in_valid !== 1'b0) begin
                    n_errors++; $display("FAIL abort_stop: grant %b addr %0d done %b required all zero", grant, weight_addr, burst_done);
                end
                abort = '0;
                req   = 4'b1111;
            end
            if (c == 7) begin
                n_checks++;
                if (grant !== 4'b0100) begin
                    n_errors++; $display("FAIL abort_next: got %b required 0100", grant);
                end
                req = '0;
            end
        end
    endtask

    task automatic test_reset_mid();
        do_reset();
        req = 4'b1000;
        for (int c = 1; c <= 7; c++) begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_errors++; $display("FAIL rstmid c%0d: got %h required %h", c, act_vec, exp_vec);
            end
        end
        n_checks++;
        if (weight_addr !== 4'd6) begin
            n_errors++; $display("FAIL rstmid_addr: got %0d required 6", weight_addr);
        end
        rst = 1'b1;
        tick();
        n_checks++;
        if (act_vec !== '0) begin
            n_errors++; $display("FAIL rstmid_zero: got %h required 0", act_vec);
        end
        rst = 1'b0;
        req = 4'b1001;
        tick();
        n_checks++;
        if (grant !== 4'b0001) begin
            n_errors++; $display("FAIL rstmid_pe0: got %b required 0001", grant);
        end
        req = '0;
        for (int c = 0; c < 10; c++) begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_errors++; $display("FAIL rstmid_drain c%0d: got %h required %h", c, act_vec, exp_vec);
            end
        end
    endtask

    task automatic test_ignored_abort();
        do_reset();
        abort = 4'b0001;
        tick(); tick();
        n_checks++;
        if (act_vec !== '0) begin
            n_errors++; $display("FAIL idle_abort: got %h required 0", act_vec);
        end
        req = 4'b0100;
        for (int c = 1; c <= 11; c++) begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_errors++; $display("FAIL ignabort c%0d: got %h required %h", c, act_vec, exp_vec);
            end
            if (c == 10) begin
                n_checks++;
                if (burst_done !== 4'b0100) begin
                    n_errors++; $display("FAIL ignabort_done: got %b required 0100", burst_done);
                end
            end
            if (m_done != 0) req = '0;
        end
        abort = '0;
    endtask

`ifdef PE_ARB_FIXED_PRIO_EN
    task automatic test_fixed();
        do_reset();
        req = 4'b1010;
        for (int c = 1; c <= 40; c++) begin
            tick();
            n_checks++;
            if (act_vec !== exp_vec || grant[3] !== 1'b0) begin
                n_errors++; $display("FAIL fixed c%0d: got %h required %h", c, act_vec, exp_vec);
            end
            if ((c - 1) % 10 == 0) begin
                n_checks++;
                if (grant !== 4'b0010) begin
                    n_errors++; $display("FAIL fixed_pe1 c%0d: got %b required 0010", c, grant);
                end
            end
        end
        req = '0;
        for (int c = 0; c < 10; c++) tick();
    endtask
`endif

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 800; c++) begin
            if ($urandom_range(3, 0) == 0) req = N'($urandom);
            abort = ($urandom_range(15, 0) == 0) ? N'($urandom) : '0;
            rst   = ($urandom_range(120, 0) == 0);
            tick();
            n_checks++;
            if (act_vec !== exp_vec) begin
                n_errors++; $display("FAIL random c%0d: got %h required %h", c, act_vec, exp_vec);
            end
        end
        rst = 1'b0; req = '0; abort = '0;
    endtask

    initial begin
        test_reset();
        test_single();
`ifdef PE_ARB_FIXED_PRIO_EN
        test_fixed();
`else
        test_fairness();
        test_abort();
        test_reset_mid();
`endif
        test_ignored_abort();
        test_random();
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule : tb_pe_weight_arbiter
`default_nettype wire
